// File: rtl/bus_arbiter.sv
// rtl/bus_arbiter.sv - two-master round-robin bus arbiter with transfer timeout
//
// Shares one bus between master 1 and master 2 and sequences each transfer to
// one of three slave in-ports: IDLE -> ARB_GRANT -> BUSY -> RELEASE -> IDLE.
//
// Ports:
//   i_clk            system clock, rising edge
//   i_rst_n          asynchronous active-low reset
//   i_m1_req         master 1 bus request, held for the whole transfer
//   i_m1_slave_sel   master 1 target slave (0..2, 3 = invalid)
//   i_m2_req         master 2 bus request
//   i_m2_slave_sel   master 2 target slave
//   i_slave_ready    per-slave ready, bit i = slave i idle/ready
//   i_trans_done     completion pulse from the selected slave
//   o_m1_grant       master 1 owns the bus
//   o_m2_grant       master 2 owns the bus
//   o_master_sel     bus mux select (0 = master 1, 1 = master 2)
//   o_slave_sel      decoder select for the target slave
//   o_slave_valid    selected slave may accept bus traffic
//   o_bus_busy       high in every state except IDLE
//   o_err_timeout    one-cycle pulse on forced release after TIMEOUT BUSY cycles
//   o_err_badsel     one-cycle pulse when the winner targets slave 3
module bus_arbiter #(
  parameter int TIMEOUT = 4096,
  parameter int CNT_W   = 12
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_m1_req,
  input  logic [1:0] i_m1_slave_sel,
  input  logic       i_m2_req,
  input  logic [1:0] i_m2_slave_sel,
  input  logic [2:0] i_slave_ready,
  input  logic       i_trans_done,
  output logic       o_m1_grant,
  output logic       o_m2_grant,
  output logic       o_master_sel,
  output logic [1:0] o_slave_sel,
  output logic       o_slave_valid,
  output logic       o_bus_busy,
  output logic       o_err_timeout,
  output logic       o_err_badsel
);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_ARB_GRANT = 2'd1,
    S_BUSY      = 2'd2,
    S_RELEASE   = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_winner;
  logic             r_last_owner;
  logic [1:0]       r_sel;
  logic [CNT_W-1:0] r_cnt;
  logic             r_m1_grant;
  logic             r_m2_grant;
  logic             r_slave_valid;
  logic             r_bus_busy;

  logic             w_any_req;
  logic             w_pick;
  logic             w_win_req;
  logic             w_sel_ready;
  logic             w_timeout_hit;
  logic             w_winner_nxt;
  logic [1:0]       w_sel_nxt;
  logic             w_owned_nxt;

  // On a tie the master that did not own the bus last time wins; a lone
  // requester wins outright (i_m2_req alone selects master 2).
  always_comb begin
    w_any_req = i_m1_req | i_m2_req;
    w_pick    = (i_m1_req && i_m2_req) ? ~r_last_owner : i_m2_req;
    w_win_req = r_winner ? i_m2_req : i_m1_req;
    case (r_sel)
      2'd0:    w_sel_ready = i_slave_ready[0];
      2'd1:    w_sel_ready = i_slave_ready[1];
      2'd2:    w_sel_ready = i_slave_ready[2];
      default: w_sel_ready = 1'b0;
    endcase
    w_timeout_hit = (r_cnt == CNT_W'(TIMEOUT - 1));
  end

  // Next-state and the two error pulses. The pulses are decoded in the cycle
  // the fault is detected so they line up with the cycle that triggers release.
  always_comb begin
    w_state_nxt   = r_state;
    o_err_timeout = 1'b0;
    o_err_badsel  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_any_req) w_state_nxt = S_ARB_GRANT;
      end
      S_ARB_GRANT: begin
        if (r_sel == 2'd3) begin
          o_err_badsel = 1'b1;
          w_state_nxt  = S_RELEASE;
        end else if (!w_win_req) begin
          w_state_nxt = S_RELEASE;
        end else if (w_sel_ready) begin
          w_state_nxt = S_BUSY;
        end
      end
      S_BUSY: begin
        // Completion and abort both win over a coincident timeout.
        if (i_trans_done || !w_win_req) begin
          w_state_nxt = S_RELEASE;
        end else if (w_timeout_hit) begin
          o_err_timeout = 1'b1;
          w_state_nxt   = S_RELEASE;
        end
      end
      S_RELEASE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Winner and target are only captured when leaving IDLE, so the loser's
  // inputs are ignored and slave_sel stays fixed for the whole ownership.
  always_comb begin
    w_winner_nxt = (r_state == S_IDLE && w_any_req) ? w_pick : r_winner;
    w_sel_nxt    = (r_state == S_IDLE && w_any_req) ?
                   (w_pick ? i_m2_slave_sel : i_m1_slave_sel) : r_sel;
    w_owned_nxt  = (w_state_nxt == S_ARB_GRANT) || (w_state_nxt == S_BUSY);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_winner      <= 1'b0;
      r_last_owner  <= 1'b1;
      r_sel         <= 2'd0;
      r_cnt         <= '0;
      r_m1_grant    <= 1'b0;
      r_m2_grant    <= 1'b0;
      r_slave_valid <= 1'b0;
      r_bus_busy    <= 1'b0;
    end else begin
      r_winner      <= w_winner_nxt;
      r_sel         <= w_sel_nxt;
      r_m1_grant    <= w_owned_nxt && !w_winner_nxt;
      r_m2_grant    <= w_owned_nxt &&  w_winner_nxt;
      // Valid lags BUSY entry by one cycle and drops with the release decision.
      r_slave_valid <= (r_state == S_BUSY) && (w_state_nxt == S_BUSY);
      r_bus_busy    <= (w_state_nxt != S_IDLE);
      r_cnt         <= (r_state == S_BUSY) ? r_cnt + 1'b1 : '0;
      if (r_state == S_RELEASE) r_last_owner <= r_winner;
    end
  end

  assign o_m1_grant    = r_m1_grant;
  assign o_m2_grant    = r_m2_grant;
  assign o_master_sel  = r_winner;
  assign o_slave_sel   = r_sel;
  assign o_slave_valid = r_slave_valid;
  assign o_bus_busy    = r_bus_busy;

endmodule
